// File: rtl/vga_scanout_if.sv
// vga_scanout_if
// Bundles the framebuffer read port and the VGA output pins of vga_scanout.
//   fb_addr     framebuffer read address {y[7:0], x[7:0]}
//   fb_rd       framebuffer read strobe
//   fb_data     {R8,G8,B8}, valid one clk after fb_rd
//   vga_r/g/b   4-bit colour channels
//   vga_hs/vs   active-low sync
//   frame_start one-clk pulse at the start of each frame
// master: the scanout block; slave: framebuffer / display side.
interface vga_scanout_if;
  logic [15:0] fb_addr;
  logic        fb_rd;
  logic [23:0] fb_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_start;

  modport master (
    output fb_addr, fb_rd, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start,
    input  fb_data
  );

  modport slave (
    input  fb_addr, fb_rd, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start,
    output fb_data
  );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout
// Scans a VGA raster, reads the 24-bit framebuffer for pixels inside a fixed
// window and drives 4-bit-per-channel colour plus active-low hsync/vsync.
// Active pixels outside the window show BORDER; blanking shows black.
// Ports:
//   clk     system clock (CLK_DIV clk per pixel)
//   rst     synchronous, active-high reset
//   io_bus  framebuffer read port and VGA outputs (vga_scanout_if.master)
// WIN_W/WIN_H default to the 256x256 graph window.
module vga_scanout #(
  parameter int          CLK_DIV  = 4,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          X0       = 192,
  parameter int          Y0       = 112,
  parameter int          WIN_W    = 256,
  parameter int          WIN_H    = 256,
  parameter logic [11:0] BORDER   = 12'h222
) (
  input  logic           clk,
  input  logic           rst,
  vga_scanout_if.master  io_bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] WX_LO  = 10'(X0);
  localparam logic [9:0] WX_HI  = 10'(X0 + WIN_W - 1);
  localparam logic [9:0] WY_LO  = 10'(Y0);
  localparam logic [9:0] WY_HI  = 10'(Y0 + WIN_H - 1);

  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_pe_d;
  logic          r_act_d;
  logic          r_win_d;
  logic          r_hs_d;
  logic          r_vs_d;
  logic [3:0]    r_vga_r;
  logic [3:0]    r_vga_g;
  logic [3:0]    r_vga_b;
  logic          r_vga_hs;
  logic          r_vga_vs;
  logic          r_frame_start;

  logic          w_pix_en;
  logic          w_active;
  logic          w_win;
  logic          w_hs_n;
  logic          w_vs_n;
  logic [7:0]    w_xoff;
  logic [7:0]    w_yoff;
  logic          w_unused_fb;

  assign w_pix_en = (r_div == DIV_LAST);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_win    = (r_h >= WX_LO) && (r_h <= WX_HI) &&
                    (r_v >= WY_LO) && (r_v <= WY_HI);
  assign w_hs_n   = !((r_h >= HS_LO) && (r_h <= HS_HI));
  assign w_vs_n   = !((r_v >= VS_LO) && (r_v <= VS_HI));
  assign w_xoff   = 8'(r_h - WX_LO);
  assign w_yoff   = 8'(r_v - WY_LO);

  // Only the top nibble of each channel reaches the 4-bit DAC.
  assign w_unused_fb = ^{io_bus.fb_data[19:16], io_bus.fb_data[11:8],
                         io_bus.fb_data[3:0]};

  assign io_bus.fb_addr     = w_win ? {w_yoff, w_xoff} : 16'h0000;
  assign io_bus.fb_rd       = w_win && w_pix_en;
  assign io_bus.vga_r       = r_vga_r;
  assign io_bus.vga_g       = r_vga_g;
  assign io_bus.vga_b       = r_vga_b;
  assign io_bus.vga_hs      = r_vga_hs;
  assign io_bus.vga_vs      = r_vga_vs;
  assign io_bus.frame_start = r_frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_pe_d        <= 1'b0;
      r_act_d       <= 1'b0;
      r_win_d       <= 1'b0;
      r_hs_d        <= 1'b1;
      r_vs_d        <= 1'b1;
      r_vga_r       <= '0;
      r_vga_g       <= '0;
      r_vga_b       <= '0;
      r_vga_hs      <= 1'b1;
      r_vga_vs      <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_pix_en ? '0 : r_div + 1'b1;
      r_pe_d        <= w_pix_en;
      r_frame_start <= 1'b0;

      // Stage 1: capture the region flags of the pixel being addressed,
      // then advance the raster.
      if (w_pix_en) begin
        r_act_d <= w_active;
        r_win_d <= w_win;
        r_hs_d  <= w_hs_n;
        r_vs_d  <= w_vs_n;
        if (r_h == H_LAST) begin
          r_h <= '0;
          if (r_v == V_LAST) begin
            r_v           <= '0;
            r_frame_start <= 1'b1;
          end else begin
            r_v <= r_v + 10'd1;
          end
        end else begin
          r_h <= r_h + 10'd1;
        end
      end

      // Stage 2: fb_data belongs to the read issued one clk earlier, so
      // colour and syncs leave together for the same pixel.
      if (r_pe_d) begin
        if (r_act_d && r_win_d) begin
          r_vga_r <= io_bus.fb_data[23:20];
          r_vga_g <= io_bus.fb_data[15:12];
          r_vga_b <= io_bus.fb_data[7:4];
        end else if (r_act_d) begin
          r_vga_r <= BORDER[11:8];
          r_vga_g <= BORDER[7:4];
          r_vga_b <= BORDER[3:0];
        end else begin
          r_vga_r <= '0;
          r_vga_g <= '0;
          r_vga_b <= '0;
        end
        r_vga_hs <= r_hs_d;
        r_vga_vs <= r_vs_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;
  // Reduced raster so whole frames fit in a short run.
  localparam int CD = 4;
  localparam int HA = 40, HF = 4, HS = 6, HB = 4;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int X0 = 10, Y0 = 5, WW = 20, WH = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [11:0] BORDER = 12'h222;

  logic        clk;
  logic        rst;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [23:0] salt = 24'h0;

  vga_scanout_if bus ();

  vga_scanout #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X0(X0), .Y0(Y0), .WIN_W(WW), .WIN_H(WH), .BORDER(BORDER)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of clk edges since the last edge that sampled rst high.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [23:0] fb_fn(input logic [15:0] a);
    return {a[15:8] ^ salt[7:0], a[7:0] ^ salt[15:8], 8'hF0 ^ salt[23:16]};
  endfunction

  // Framebuffer: data for a read appears one clk later, junk otherwise.
  always @(posedge clk) bus.fb_data <= bus.fb_rd ? fb_fn(bus.fb_addr) : 24'($urandom);

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  function automatic bit in_win(input int h, input int v);
    return (h >= X0) && (h < X0 + WW) && (v >= Y0) && (v < Y0 + WH);
  endfunction

  // Expected outputs after c edges: pixel k owns clocks k*CD..k*CD+CD-1 and
  // is shown from 2 clk after its last (pix_en) clock, for CD clocks.
  function automatic exp_t model(input int unsigned c);
    exp_t e;
    int m, h, v, n, oh, ov;
    logic [23:0] d;
    m = int'((c / CD) % FR);
    h = m % HT;
    v = m / HT;
    e.rd   = in_win(h, v) && ((c % CD) == CD - 1);
    e.addr = in_win(h, v) ? {8'(v - Y0), 8'(h - X0)} : 16'h0000;
    e.rgb  = 12'h000;
    e.hs   = 1'b1;
    e.vs   = 1'b1;
    if (c >= CD + 1) begin
      n  = int'(((c - CD - 1) / CD) % FR);
      oh = n % HT;
      ov = n / HT;
      if (oh < HA && ov < VA) begin
        if (in_win(oh, ov)) begin
          d = fb_fn({8'(ov - Y0), 8'(oh - X0)});
          e.rgb = {d[23:20], d[15:12], d[7:4]};
        end else begin
          e.rgb = BORDER;
        end
      end
      e.hs = !(oh >= HA + HF && oh < HA + HF + HS);
      e.vs = !(ov >= VA + VF && ov < VA + VF + VS);
    end
    e.fs = (c > 0) && ((c % CD) == 0) && (((c / CD) % FR) == 0);
    return e;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto_cycle(input int unsigned target, output bit ok);
    int g = 0;
    while (cyc != target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    ok = (cyc == target);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb: got %h expected 000", {bus.vga_r, bus.vga_g, bus.vga_b});
    end
    checks++;
    if ({bus.vga_hs, bus.vga_vs, bus.frame_start, bus.fb_rd} !== 4'b1100) begin
      errors++; $display("FAIL reset_ctl: got hs/vs/fs/rd=%b expected 1100",
                         {bus.vga_hs, bus.vga_vs, bus.frame_start, bus.fb_rd});
    end
    rst = 1'b0;
    for (int k = 0; k < CD + 3; k++) begin
      @(negedge clk);
      e = model(cyc);
      if (cyc == CD - 1) begin
        checks++;
        if (bus.fb_rd !== 1'b0) begin
          errors++; $display("FAIL first_fb_rd: got %b expected 0", bus.fb_rd);
        end
      end
      checks++;
      if ({bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs} !== {e.rgb, e.hs, e.vs}) begin
        errors++; $display("FAIL post_reset_out c=%0d: got %h/%b%b expected %h/%b%b", cyc,
                           {bus.vga_r, bus.vga_g, bus.vga_b}, bus.vga_hs, bus.vga_vs, e.rgb, e.hs, e.vs);
      end
    end
  endtask

  task automatic test_hsync();
    int fall1 = -1, fall2 = -1, low_len = 0, n;
    bit prev = 1'b1;
    do_reset(2);
    for (int k = 0; k < 3 * HT * CD && fall2 < 0; k++) begin
      @(negedge clk);
      if (prev && !bus.vga_hs) begin
        if (fall1 < 0) fall1 = int'(cyc);
        else fall2 = int'(cyc);
      end
      if (!bus.vga_hs && fall1 >= 0 && fall2 < 0) low_len++;
      if (cyc >= CD + 1) begin
        n = int'((cyc - CD - 1) / CD);
        if ((n % HT) >= HA) begin
          checks++;
          if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h000) begin
            errors++; $display("FAIL blank_rgb h=%0d: got %h expected 000", n % HT,
                               {bus.vga_r, bus.vga_g, bus.vga_b});
          end
        end
      end
      prev = bus.vga_hs;
    end
    checks++;
    if (fall1 != (HA + HF + 1) * CD + 1) begin
      errors++; $display("FAIL hs_start: got clk %0d expected %0d", fall1, (HA + HF + 1) * CD + 1);
    end
    checks++;
    if (low_len != HS * CD) begin
      errors++; $display("FAIL hs_width: got %0d expected %0d", low_len, HS * CD);
    end
    checks++;
    if (fall2 - fall1 != HT * CD) begin
      errors++; $display("FAIL line_period: got %0d expected %0d", fall2 - fall1, HT * CD);
    end
  endtask

  task automatic test_vsync_frame();
    int vs_fall = -1, vs_len = 0, fs1 = -1, fs2 = -1, fs_cnt = 0, w = 0, wmax = 0;
    bit prev_vs = 1'b1;
    do_reset(1);
    for (int k = 0; k < 2 * FR * CD + 3; k++) begin
      @(negedge clk);
      if (prev_vs && !bus.vga_vs && vs_fall < 0) vs_fall = int'(cyc);
      if (!bus.vga_vs && fs1 < 0) vs_len++;
      if (bus.frame_start) begin
        if (w == 0) begin
          fs_cnt++;
          if (fs1 < 0) fs1 = int'(cyc);
          else if (fs2 < 0) fs2 = int'(cyc);
        end
        w++;
        if (w > wmax) wmax = w;
      end else begin
        w = 0;
      end
      prev_vs = bus.vga_vs;
    end
    checks++;
    if (vs_fall != ((VA + VF) * HT + 1) * CD + 1) begin
      errors++; $display("FAIL vs_start: got clk %0d expected %0d", vs_fall, ((VA + VF) * HT + 1) * CD + 1);
    end
    checks++;
    if (vs_len != VS * HT * CD) begin
      errors++; $display("FAIL vs_width: got %0d expected %0d", vs_len, VS * HT * CD);
    end
    checks++;
    if (fs1 != FR * CD) begin
      errors++; $display("FAIL fs_first: got clk %0d expected %0d", fs1, FR * CD);
    end
    checks++;
    if (fs2 - fs1 != FR * CD) begin
      errors++; $display("FAIL fs_period: got %0d expected %0d", fs2 - fs1, FR * CD);
    end
    checks++;
    if (fs_cnt != 2 || wmax != 1) begin
      errors++; $display("FAIL fs_pulses: got count %0d width %0d expected 2 and 1", fs_cnt, wmax);
    end
  endtask

  typedef struct {
    int          h;
    int          v;
    bit          rd;
    logic [15:0] addr;
    logic [11:0] rgb;
  } wpt_t;

  task automatic test_window_border();
    wpt_t pts[6];
    bit ok;
    pts[0] = '{15, 4, 1'b0, 16'h0000, 12'h222};
    pts[1] = '{9, 5, 1'b0, 16'h0000, 12'h222};
    pts[2] = '{10, 5, 1'b1, 16'h0000, 12'h00F};
    pts[3] = '{30, 10, 1'b0, 16'h0000, 12'h222};
    pts[4] = '{40, 10, 1'b0, 16'h0000, 12'h000};
    pts[5] = '{29, 16, 1'b1, 16'h0B13, 12'h01F};
    salt = 24'h0;
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      goto_cycle(int'((pts[i].v * HT + pts[i].h) * CD + CD - 1), ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL win_reach (%0d,%0d): got clk %0d", pts[i].h, pts[i].v, cyc);
      end
      checks++;
      if ({bus.fb_rd, bus.fb_addr} !== {pts[i].rd, pts[i].addr}) begin
        errors++; $display("FAIL win_read (%0d,%0d): got rd=%b addr=%h expected rd=%b addr=%h",
                           pts[i].h, pts[i].v, bus.fb_rd, bus.fb_addr, pts[i].rd, pts[i].addr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.vga_r, bus.vga_g, bus.vga_b} !== pts[i].rgb) begin
        errors++; $display("FAIL win_rgb (%0d,%0d): got %h expected %h", pts[i].h, pts[i].v,
                           {bus.vga_r, bus.vga_g, bus.vga_b}, pts[i].rgb);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int unsigned stop;
    int fs_at;
    for (int t = 0; t < 2; t++) begin
      salt = 24'($urandom);
      do_reset(1);
      stop = $urandom_range(CD + 2, FR * CD - 1);
      fs_at = -1;
      for (int ph = 0; ph < 2; ph++) begin
        for (int k = 0; k < FR * CD + 2 * CD; k++) begin
          if (ph == 0 && cyc == stop) break;
          if (ph == 1 && fs_at >= 0) break;
          @(negedge clk);
          e = model(cyc);
          checks++;
          if ({bus.fb_rd, bus.fb_addr} !== {e.rd, e.addr}) begin
            errors++; $display("FAIL rnd_read c=%0d: got rd=%b addr=%h expected rd=%b addr=%h",
                               cyc, bus.fb_rd, bus.fb_addr, e.rd, e.addr);
          end
          checks++;
          if ({bus.vga_r, bus.vga_g, bus.vga_b} !== e.rgb) begin
            errors++; $display("FAIL rnd_rgb c=%0d: got %h expected %h", cyc,
                               {bus.vga_r, bus.vga_g, bus.vga_b}, e.rgb);
          end
          checks++;
          if ({bus.vga_hs, bus.vga_vs, bus.frame_start} !== {e.hs, e.vs, e.fs}) begin
            errors++; $display("FAIL rnd_sync c=%0d: got hs/vs/fs=%b expected %b", cyc,
                               {bus.vga_hs, bus.vga_vs, bus.frame_start}, {e.hs, e.vs, e.fs});
          end
          if (ph == 1 && bus.frame_start) fs_at = int'(cyc);
        end
        if (ph == 0) begin
          // One-clk reset pulse in the middle of the frame.
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          checks++;
          if ({bus.vga_r, bus.vga_g, bus.vga_b, bus.frame_start} !== 13'h0) begin
            errors++; $display("FAIL midrst_state: got rgb=%h fs=%b expected 000/0",
                               {bus.vga_r, bus.vga_g, bus.vga_b}, bus.frame_start);
          end
        end
      end
      checks++;
      if (fs_at != FR * CD) begin
        errors++; $display("FAIL midrst_next_fs: got clk %0d expected %0d", fs_at, FR * CD);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_hsync();
    test_vsync_frame();
    test_window_border();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Framebuffer reader and VGA timing generator for the 256x256 graph display. It scans a 640x480@60 raster, reads the 24-bit RGB framebuffer written by the graph renderer, and drives 4-bit-per-channel VGA outputs with hsync and vsync. The image sits in a fixed window inside the active area; active pixels outside the window show a border colour.

## Interface
- CLK_DIV, 4: clk cycles per pixel; must be ≥2 (100 MHz clk gives a 25 MHz pixel rate).
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels (H_TOTAL = 800).
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines (V_TOTAL = 525).
- X0, 192; Y0, 112: top-left corner of the 256x256 window.
- BORDER, 12'h222: {R4,G4,B4} colour for active pixels outside the window.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- fb_addr  out  16  framebuffer read address {y[7:0], x[7:0]}.
- fb_rd  out  1  read strobe for the framebuffer.
- fb_data  in  24  {R8,G8,B8}; valid exactly 1 clk after fb_rd.
- vga_r, vga_g, vga_b  out  4 each  pixel colour.
- vga_hs, vga_vs  out  1 each  sync outputs, active-low.
- frame_start  out  1  one-clk pulse at the start of each frame.

## Operation
- **Divider.** div counts 0..CLK_DIV-1 and wraps. pix_en = (div == CLK_DIV-1).
- **Raster counters.** h counts 0..799 and v counts 0..524. On a clk edge with pix_en:
  - h increments.
  - At h = 799, h wraps to 0 and v increments.
  - At (799, 524), the counters wrap to (0, 0).
- **Region decode** (combinational from h and v):
  - active = (h < 640) && (v < 480).
  - win = (X0 ≤ h ≤ X0+255) && (Y0 ≤ v ≤ Y0+255).
  - hs_n = !(656 ≤ h ≤ 751).
  - vs_n = !(490 ≤ v ≤ 491).
  - All compares use unsigned arithmetic of at least 10 bits. Window offsets are (h-X0)[7:0] and (v-Y0)[7:0].
- **Framebuffer read** (combinational):
  - fb_addr = win ? {(v-Y0)[7:0], (h-X0)[7:0]} : 16'h0000.
  - fb_rd = win && pix_en.
- **Stage 1.** On a pix_en edge, register act_d, win_d, hs_d and vs_d from the current (h, v). Register pe_d = pix_en on every edge.
- **Stage 2.** On an edge with pe_d = 1:
  - If act_d && win_d: {vga_r, vga_g, vga_b} ← {fb_data[23:20], fb_data[15:12], fb_data[7:4]}.
  - If act_d && !win_d: the colour outputs ← BORDER.
  - If !act_d: the colour outputs ← 0.
  - vga_hs ← hs_d and vga_vs ← vs_d.
- **frame_start.** Registered. It is 1 for the single clk following the edge on which the counters wrap (799, 524) → (0, 0). Otherwise it is 0.
- **Framebuffer contract.** The framebuffer is read-only from this block. No handshake back-pressure exists; fb_data is sampled unconditionally 1 clk after fb_rd.

## Timing
- **Reset values:**
  - div = 0, h = 0, v = 0, pe_d = 0.
  - act_d = 0, win_d = 0, hs_d = 1, vs_d = 1.
  - vga_r = vga_g = vga_b = 0.
  - vga_hs = 1, vga_vs = 1.
  - frame_start = 0.
- **Reset mid-frame.** Takes effect on the next edge and overrides all other updates. The raster restarts at (0, 0). frame_start does not pulse for this restart.
- **First pixel after reset.** rst deasserts before edge E0.
  - pix_en is first high during the CLK_DIV-th clk, i.e. after edge E(CLK_DIV-1), with (h, v) = (0, 0).
  - Outputs for pixel (0, 0) appear after edge E(CLK_DIV+1).
- **Latency.** The output for pixel (h, v) updates 2 clk after the start of its pix_en cycle and holds for CLK_DIV clk. hs, vs and colour stay aligned to the same pixel.
- **Frame period.** 800 × 525 × CLK_DIV clk (1,680,000 at CLK_DIV = 4).
- **Window edges.** Pixel X0+255 is the last window pixel and X0+256 is border. Pixel X0-1 is border.

## Test plan
- **Reset.** Hold rst 5 clk, then release. Require all outputs at reset values. Require the first fb_rd = 0, because (0, 0) is outside the window. Require vga_hs = vga_vs = 1.
- **Horizontal timing** (CLK_DIV = 4). Require:
  - vga_hs low for 384 clk per line, starting 2 clk after the pix_en cycle of h = 656.
  - Line period of 3200 clk.
  - Colour outputs 0 for h ≥ 640.
- **Vertical timing and frame_start.** Require:
  - vga_vs low for exactly 2 lines (v = 490, 491).
  - frame_start pulses exactly 1,680,000 clk apart, each pulse 1 clk wide.
- **Window read.** Use a framebuffer model returning fb_data = {addr[15:8], addr[7:0], 8'hF0}.
  - Pixel (192, 112): fb_addr = 16'h0000, output r = g = 0, b = 4'hF.
  - Pixel (447, 367): fb_addr = 16'hFFFF, output r = g = b = 4'hF.
- **Border.** Pixels (191, 112), (448, 200) and (300, 111) output 12'h222 with fb_rd = 0. Pixel (640, 200) outputs 0.
- **Mid-frame reset.** Assert rst for 1 clk at (h, v) = (400, 300). Require:
  - The next pix_en cycle shows (0, 0).
  - No frame_start pulse for this restart.
  - The next frame_start is 1,680,000 clk after rst falls, ±CLK_DIV.
